// File: rtl/finv_table_loader_if.sv
// Write-side bus between the reciprocal-seed table loader and the table RAM / its controller.
interface finv_table_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_a;
  logic [23:0]       wr_b;

  modport master (
    input  start,
    output busy, done, wr_en, wr_addr, wr_a, wr_b
  );

  modport slave (
    output start,
    input  busy, done, wr_en, wr_addr, wr_a, wr_b
  );
endinterface

// File: rtl/finv_table_loader.sv
// Builds the finv reciprocal-seed table at run time: one restoring division per entry,
// averaging consecutive quotients into b, then a = (b*b) >> 24, written through the RAM write port.
module finv_table_loader #(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rstn,
  finv_table_loader_if.master bus
);
  localparam int unsigned D     = 25 + ADDR_W;
  localparam int          CNT_W = $clog2(D);
  localparam int          DIV_W = ADDR_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV0,
    S_DIV,
    S_MUL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DIV_W-1:0]  rem_q;
  logic [24:0]       quo_q;
  logic [24:0]       q_prev_q;
  logic [23:0]       b_q;
  logic [23:0]       a_q;

  logic              div_last;
  logic              dividing;
  logic [DIV_W-1:0]  divisor;
  logic [DIV_W-1:0]  rem_base;
  logic [DIV_W:0]    rem_sh;
  logic [DIV_W:0]    diff;
  logic              fits;
  logic [DIV_W-1:0]  rem_nx;
  logic [24:0]       quo_nx;
  logic [23:0]       b_nx;

  assign div_last = (cnt_q == CNT_W'(D - 1));
  assign dividing = (state_q == S_DIV0) || (state_q == S_DIV);

  // Divisor is N+i while seeding q(N), N+i+1 afterwards; dividend 2^(24+ADDR_W) is a lone 1 at step 0.
  always_comb begin
    divisor  = {2'b01, {ADDR_W{1'b0}}} + DIV_W'(idx_q) + DIV_W'(state_q == S_DIV);
    rem_base = (cnt_q == '0) ? '0 : rem_q;
    rem_sh   = {rem_base, (cnt_q == '0)};
    diff     = rem_sh - {1'b0, divisor};
    // divisor <= 2^(DIV_W-1), so the top bit of diff alone tells a borrow from a fit
    fits     = ~diff[DIV_W];
    rem_nx   = fits ? diff[DIV_W-1:0] : rem_sh[DIV_W-1:0];
    quo_nx   = {quo_q[23:0], fits};
    b_nx     = 24'((q_prev_q + quo_q) >> 1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_DIV0;
      S_DIV0:  if (div_last) state_d = S_DIV;
      S_DIV:   if (div_last) state_d = S_MUL;
      S_MUL:   state_d = S_WRITE;
      S_WRITE: state_d = (idx_q == '1) ? S_DONE : S_DIV;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      q_prev_q <= '0;
      b_q      <= '0;
      a_q      <= '0;
    end else begin
      if (dividing) begin
        cnt_q <= div_last ? '0 : cnt_q + 1'b1;
        rem_q <= rem_nx;
        quo_q <= quo_nx;
      end else begin
        cnt_q <= '0;
      end

      if (state_q == S_DIV0 && div_last) q_prev_q <= quo_nx;
      if (state_q == S_IDLE && bus.start) idx_q <= '0;

      if (state_q == S_MUL) begin
        b_q <= b_nx;
        a_q <= 24'(({24'b0, b_nx} * {24'b0, b_nx}) >> 24);
      end

      // idx wraps back to 0 after the last entry, ready for the next build
      if (state_q == S_WRITE) begin
        q_prev_q <= quo_q;
        idx_q    <= idx_q + 1'b1;
      end
    end
  end

  assign bus.busy    = dividing || (state_q == S_MUL) || (state_q == S_WRITE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.wr_en   = (state_q == S_WRITE);
  assign bus.wr_addr = idx_q;
  assign bus.wr_a    = a_q;
  assign bus.wr_b    = b_q;
endmodule

// File: tb/tb_finv_table_loader.sv
// Scoreboarded bench for finv_table_loader: randomized start/abort timing against a formula-level table model.
module tb_finv_table_loader;
  localparam int AW       = 10;
  localparam int N        = 1 << AW;
  localparam int D        = 25 + AW;
  localparam int FIRST_WR = 2 * D + 2;
  localparam int PERIOD   = D + 2;
  localparam int DONE_CYC = FIRST_WR + PERIOD * (N - 1) + 1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  finv_table_loader_if #(.ADDR_W(AW)) bus();
  finv_table_loader #(.ADDR_W(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    int          addr;
    logic [63:0] a;
    logic [63:0] b;
  } wr_t;

  wr_t  exp_q[$];
  int   done_q[$];
  logic [63:0] ref_a [N];
  logic [63:0] ref_b [N];

  function automatic longint unsigned quot(longint unsigned d);
    return (64'd1 << (24 + AW)) / d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_build(input int base, input int count);
    wr_t e;
    for (int i = 0; i < count; i++) begin
      e.cyc  = base + FIRST_WR + PERIOD * i;
      e.addr = i;
      e.a    = ref_a[i];
      e.b    = ref_b[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},    64'(bus.busy),    64'd0);
    chk({tag, "_done"},    64'(bus.done),    64'd0);
    chk({tag, "_wr_en"},   64'(bus.wr_en),   64'd0);
    chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, "_wr_a"},    64'(bus.wr_a),    64'd0);
    chk({tag, "_wr_b"},    64'(bus.wr_b),    64'd0);
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_t e;
    int  dc;
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d at cycle %0d, expected no write", bus.wr_addr, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        chk("wr_a", 64'(bus.wr_a), e.a);
        chk("wr_b", 64'(bus.wr_b), e.b);
        if (bus.wr_addr == 0) begin
          chk("entry0_b", 64'(bus.wr_b), 64'd16769031);
          chk("entry0_a", 64'(bus.wr_a), 64'd16760849);
        end
        if (bus.wr_addr == AW'(N - 1)) begin
          chk("entry_last_b", 64'(bus.wr_b), 64'd8390657);
          chk("entry_last_a", 64'(bus.wr_a), 64'd4196353);
        end
      end
    end
    if (bus.done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: at cycle %0d, expected no done", cyc);
      end else begin
        dc = done_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(dc));
        chk("done_busy", 64'(bus.busy), 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a, base_b, base_c;
    int w, rp, hi_at, r_at;
    longint unsigned bb;

    for (int i = 0; i < N; i++) begin
      bb       = ((quot(N + i) + quot(N + i + 1)) >> 1) & 64'hFF_FFFF;
      ref_b[i] = bb;
      ref_a[i] = (bb * bb) >> 24;
    end

    bus.start = 1'b0;
    #1 rstn = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);

    // Build A: random pulse width, ignored re-pulse, then start held for a back-to-back build B
    chk("a_idle_busy", 64'(bus.busy), 64'd0);
    base_a = cyc;
    push_build(base_a, N);
    done_q.push_back(base_a + DONE_CYC);
    bus.start = 1'b1;
    w     = $urandom_range(1, 20);
    rp    = $urandom_range(200, 36000);
    hi_at = $urandom_range(37000, 37900);
    wait_until(base_a + 1);
    chk("a_busy_c1", 64'(bus.busy), 64'd1);
    wait_until(base_a + w);
    bus.start = 1'b0;
    wait_until(base_a + rp);
    bus.start = 1'b1;
    wait_until(base_a + rp + 1);
    bus.start = 1'b0;
    wait_until(base_a + hi_at);
    bus.start = 1'b1;
    base_b = base_a + DONE_CYC + 1;
    push_build(base_b, N);
    wait_until(base_a + DONE_CYC);
    chk("a_done_busy", 64'(bus.busy), 64'd0);
    wait_until(base_b);
    chk("a_done_seen", 64'(done_q.size()), 64'd0);
    chk("a_all_written", 64'(exp_q.size()), 64'(N));
    chk("b_c0_busy", 64'(bus.busy), 64'd0);
    chk("b_c0_done", 64'(bus.done), 64'd0);
    wait_until(base_b + 1);
    chk("b_busy_c1", 64'(bus.busy), 64'd1);
    wait_until(base_b + 5);
    bus.start = 1'b0;

    // Abort build B while entry 300 is dividing
    r_at = $urandom_range(FIRST_WR + PERIOD * 299 + 1, FIRST_WR + PERIOD * 300 - 2);
    wait_until(base_b + r_at);
    chk("b_pending_at_abort", 64'(exp_q.size()), 64'(N - 300));
    #2 rstn = 1'b0;
    exp_q.delete();
    #1 check_outputs_zero("abort");
    repeat ($urandom_range(2, 5)) @(negedge clk);
    rstn = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);

    // Build C: fresh start after abort, first 16 entries on the original schedule
    chk("c_idle_busy", 64'(bus.busy), 64'd0);
    base_c = cyc;
    push_build(base_c, 16);
    bus.start = 1'b1;
    wait_until(base_c + 1);
    bus.start = 1'b0;
    chk("c_busy_c1", 64'(bus.busy), 64'd1);
    wait_until(base_c + FIRST_WR + PERIOD * 15 + 1);
    chk("c_written", 64'(exp_q.size()), 64'd0);
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
